// File: rtl/dtlb_refill_walker_if.sv
// Bundle of every signal between the dTLB refill walker and its neighbours:
// the lookup-pipeline miss port, the L2 table-read port and the dwtlb_way write port.
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

interface dtlb_refill_walker_if #(
    parameter int DATA_W = `dtlbData_width,
    parameter int VA_W   = 50,
    parameter int PA_W   = 44
);
    // Handshakes: a miss moves when miss_en && miss_ready; a table read moves when
    // req_valid && req_ready, and req_valid/req_addr hold until then; rsp_valid is a
    // one-cycle push with no back-pressure.
    logic              miss_en;
    logic [VA_W-1:0]   miss_addr;
    logic [1:0]        lru0, lru1, lru2, lru3;
    logic              miss_ready;
    logic [PA_W-1:0]   ptbr;
    logic              flush;
    logic              req_valid;
    logic [PA_W-1:0]   req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [127:0]      rsp_data;
    logic              rsp_err;
    logic              write_wen;
    logic [1:0]        write_way;
    logic [VA_W-1:0]   write_addr;
    logic [DATA_W-1:0] write_data0, write_data1;
    logic              busy;
    logic              fault;
    logic [2:0]        state_dbg;

    modport master (
        input  miss_en, miss_addr, lru0, lru1, lru2, lru3, ptbr, flush,
               req_ready, rsp_valid, rsp_data, rsp_err,
        output miss_ready, req_valid, req_addr, write_wen, write_way, write_addr,
               write_data0, write_data1, busy, fault, state_dbg
    );

    modport slave (
        output miss_en, miss_addr, lru0, lru1, lru2, lru3, ptbr, flush,
               req_ready, rsp_valid, rsp_data, rsp_err,
        input  miss_ready, req_valid, req_addr, write_wen, write_way, write_addr,
               write_data0, write_data1, busy, fault, state_dbg
    );
endinterface

// File: rtl/dtlb_refill_walker.sv
// dTLB refill engine: two-level page-table walk for one miss, then a single-cycle
// write of the even/odd translation pair into the LRU-selected way.
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

module dtlb_refill_walker #(
    parameter int DATA_W = `dtlbData_width,
    parameter int VA_W   = 50,
    parameter int PA_W   = 44
) (
    input logic                clk,
    input logic                rst,
    dtlb_refill_walker_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L2_REQ  = 3'd3,
        L2_WAIT = 3'd4,
        WRITE   = 3'd5,
        DRAIN   = 3'd6
    } state_t;

    state_t             state, state_nx;
    logic [VA_W-1:0]    va_q;
    logic [PA_W-16:0]   root_q;
    logic [PA_W-17:0]   base_q;
    logic [1:0]         way_q;
    logic [DATA_W-1:0]  data0_q, data1_q;
    logic               fault_q;

    logic               accept;
    logic               upper_bad;
    logic               l1_ok, l2_ok;
    logic [1:0]         victim;
    logic [1:0]         best_lru;
    logic [1:0]         lru_v [4];

    assign accept    = (state == IDLE) && bus.miss_en && !bus.flush;
    assign upper_bad = |bus.miss_addr[VA_W-1:25];
    assign l1_ok     = !bus.rsp_err && bus.rsp_data[0];
    assign l2_ok     = !bus.rsp_err && (va_q[0] ? bus.rsp_data[64] : bus.rsp_data[0]);

    // Minimum-LRU scan with strict compare: a zero entry is always the minimum,
    // so "first zero" and "first minimum" collapse into one rule.
    always_comb begin
        lru_v[0] = bus.lru0;
        lru_v[1] = bus.lru1;
        lru_v[2] = bus.lru2;
        lru_v[3] = bus.lru3;
        victim   = 2'd0;
        best_lru = lru_v[0];
        for (int i = 1; i < 4; i++) begin
            if (lru_v[i] < best_lru) begin
                best_lru = lru_v[i];
                victim   = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !upper_bad) state_nx = L1_REQ;
            L1_REQ:  if (bus.flush)          state_nx = bus.req_ready ? DRAIN : IDLE;
                     else if (bus.req_ready) state_nx = L1_WAIT;
            L1_WAIT: if (bus.rsp_valid)      state_nx = (l1_ok && !bus.flush) ? L2_REQ : IDLE;
                     else if (bus.flush)     state_nx = DRAIN;
            L2_REQ:  if (bus.flush)          state_nx = bus.req_ready ? DRAIN : IDLE;
                     else if (bus.req_ready) state_nx = L2_WAIT;
            L2_WAIT: if (bus.rsp_valid)      state_nx = (l2_ok && !bus.flush) ? WRITE : IDLE;
                     else if (bus.flush)     state_nx = DRAIN;
            WRITE:   state_nx = IDLE;
            DRAIN:   if (bus.rsp_valid)      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.write_wen  = 1'b0;
        bus.miss_ready = 1'b0;
        bus.busy       = 1'b1;
        case (state)
            IDLE: begin
                bus.miss_ready = 1'b1;
                bus.busy       = 1'b0;
            end
            L1_REQ: begin
                bus.req_valid = 1'b1;
                bus.req_addr  = {root_q, va_q[24:13], 3'b000};
            end
            L2_REQ: begin
                bus.req_valid = 1'b1;
                bus.req_addr  = {base_q, va_q[12:1], 4'b0000};
            end
            WRITE:   bus.write_wen = !bus.flush;
            default: ;
        endcase
    end

    // A flushed walk must stay silent, so responses seen alongside flush neither
    // latch data nor raise fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            va_q    <= '0;
            root_q  <= '0;
            base_q  <= '0;
            way_q   <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= 1'b0;
            if (accept) begin
                va_q    <= bus.miss_addr;
                root_q  <= bus.ptbr[PA_W-1:15];
                way_q   <= victim;
                fault_q <= upper_bad;
            end
            if (state == L1_WAIT && bus.rsp_valid && !bus.flush) begin
                if (l1_ok) base_q  <= bus.rsp_data[PA_W-1:16];
                else       fault_q <= 1'b1;
            end
            if (state == L2_WAIT && bus.rsp_valid && !bus.flush) begin
                if (l2_ok) begin
                    data0_q <= bus.rsp_data[DATA_W-1:0];
                    data1_q <= bus.rsp_data[64+DATA_W-1:64];
                end else begin
                    fault_q <= 1'b1;
                end
            end
        end
    end

    assign bus.write_way   = way_q;
    assign bus.write_addr  = va_q;
    assign bus.write_data0 = data0_q;
    assign bus.write_data1 = data1_q;
    assign bus.fault       = fault_q;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_dtlb_refill_walker.sv
// Directed bench for dtlb_refill_walker: clean walks, victim choice, faults,
// back-pressure, flush with late response, and reset mid-walk.
module tb_dtlb_refill_walker;
    localparam int DATA_W = 64;
    localparam int VA_W   = 50;
    localparam int PA_W   = 44;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_req = 0;
    int   req_base;

    dtlb_refill_walker_if #(.DATA_W(DATA_W), .VA_W(VA_W), .PA_W(PA_W)) bus();

    dtlb_refill_walker #(.DATA_W(DATA_W), .VA_W(VA_W), .PA_W(PA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.req_valid && bus.req_ready) n_req <= n_req + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [VA_W-1:0] mk_va(input logic [24:0] up, input logic [11:0] i1,
                                              input logic [11:0] i2, input logic odd);
        return {up, i1, i2, odd};
    endfunction

    task automatic issue_miss(input logic [VA_W-1:0] va, input logic [PA_W-1:0] root,
                              input logic [1:0] l0, input logic [1:0] l1,
                              input logic [1:0] l2, input logic [1:0] l3);
        bus.miss_en   = 1'b1;
        bus.miss_addr = va;
        bus.ptbr      = root;
        bus.lru0 = l0; bus.lru1 = l1; bus.lru2 = l2; bus.lru3 = l3;
        tick();
        bus.miss_en = 1'b0;
    endtask

    task automatic respond(input logic [127:0] data, input logic err);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = data;
        bus.rsp_err   = err;
        tick();
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_data  = '0;
    endtask

    logic [VA_W-1:0] va;
    logic [63:0]     e_ok;
    logic [63:0]     pte0, pte1;

    initial begin
        rst = 1'b1;
        bus.miss_en = 1'b0; bus.miss_addr = '0; bus.ptbr = '0; bus.flush = 1'b0;
        bus.lru0 = 2'd0; bus.lru1 = 2'd0; bus.lru2 = 2'd0; bus.lru3 = 2'd0;
        bus.req_ready = 1'b1; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.rsp_err = 1'b0;
        e_ok = 64'h0000_0000_0800_0001;
        repeat (3) tick();
        check("rst_miss_ready", bus.miss_ready, 1);
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_write_wen", bus.write_wen, 0);
        check("rst_req_addr", bus.req_addr, 0);
        rst = 1'b0;
        tick();

        // Clean walk, best-case timing: miss cycle 0 .. write cycle 5, ready cycle 6.
        va   = mk_va(25'h0, 12'h005, 12'hABC, 1'b0);
        pte0 = 64'h0000_0000_1234_5001;
        pte1 = 64'h0000_0000_5678_9003;
        issue_miss(va, 44'h123_4560_0000, 2'd3, 2'd2, 2'd0, 2'd1);
        check("c1_req_valid", bus.req_valid, 1);
        check("c1_req_addr", bus.req_addr, 44'h123_4560_0028);
        check("c1_miss_ready", bus.miss_ready, 0);
        check("c1_busy", bus.busy, 1);
        tick();
        check("c2_req_valid", bus.req_valid, 0);
        respond({64'h0, e_ok}, 1'b0);
        check("c3_req_valid", bus.req_valid, 1);
        check("c3_req_addr", bus.req_addr, 44'h000_0800_ABC0);
        tick();
        respond({pte1, pte0}, 1'b0);
        check("c5_write_wen", bus.write_wen, 1);
        check("c5_write_way", bus.write_way, 2);
        check("c5_write_addr", bus.write_addr, va);
        check("c5_write_data0", bus.write_data0, pte0);
        check("c5_write_data1", bus.write_data1, pte1);
        tick();
        check("c6_write_wen", bus.write_wen, 0);
        check("c6_miss_ready", bus.miss_ready, 1);

        // Upper VA bits set: fault one cycle after acceptance, no request.
        req_base = n_req;
        issue_miss(mk_va(25'h1, 12'h001, 12'h001, 1'b0), 44'h0, 2'd0, 2'd0, 2'd0, 2'd0);
        check("up_fault", bus.fault, 1);
        check("up_req_valid", bus.req_valid, 0);
        check("up_miss_ready", bus.miss_ready, 1);
        tick();
        check("up_fault_off", bus.fault, 0);
        check("up_busy", bus.busy, 0);
        check("up_no_req", n_req - req_base, 0);

        // Back-pressure on L1 request for 7 cycles, then invalid L1 entry.
        req_base = n_req;
        bus.req_ready = 1'b0;
        issue_miss(mk_va(25'h0, 12'h3FF, 12'h001, 1'b0), 44'hFFF_FFFF_8000, 2'd1, 2'd1, 2'd1, 2'd1);
        for (int i = 0; i < 7; i++) begin
            check("bp_req_valid", bus.req_valid, 1);
            check("bp_req_addr", bus.req_addr, 44'hFFF_FFFF_9FF8);
            tick();
        end
        bus.req_ready = 1'b1;
        check("bp_req_addr_rel", bus.req_addr, 44'hFFF_FFFF_9FF8);
        tick();
        check("bp_wait_req_valid", bus.req_valid, 0);
        respond({64'h0, 64'h0000_0000_0800_0000}, 1'b0);
        check("l1inv_fault", bus.fault, 1);
        check("l1inv_busy", bus.busy, 0);
        tick();
        tick();
        check("l1inv_fault_off", bus.fault, 0);
        check("bp_one_req", n_req - req_base, 1);

        // L2 response with bus error.
        issue_miss(mk_va(25'h0, 12'h002, 12'h004, 1'b0), 44'h0, 2'd2, 2'd2, 2'd2, 2'd2);
        tick();
        respond({64'h0, e_ok}, 1'b0);
        tick();
        respond({pte1, pte0}, 1'b1);
        check("l2err_fault", bus.fault, 1);
        check("l2err_write_wen", bus.write_wen, 0);
        tick();
        check("l2err_fault_off", bus.fault, 0);
        check("l2err_busy", bus.busy, 0);

        // Flush in L1_WAIT; response three cycles later is drained.
        issue_miss(mk_va(25'h0, 12'h010, 12'h020, 1'b1), 44'h0, 2'd0, 2'd0, 2'd0, 2'd0);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("fl_busy", bus.busy, 1);
        tick();
        tick();
        check("fl_miss_ready_pre", bus.miss_ready, 0);
        respond({64'h0, e_ok}, 1'b0);
        check("fl_miss_ready", bus.miss_ready, 1);
        check("fl_fault", bus.fault, 0);
        check("fl_req_valid", bus.req_valid, 0);

        // Next miss completes: odd page, victim fallback to way 1.
        va   = mk_va(25'h0, 12'h007, 12'h123, 1'b1);
        pte0 = 64'h0000_0000_DEAD_BEE0;
        pte1 = 64'h0000_0000_CAFE_F00D;
        issue_miss(va, 44'h0, 2'd3, 2'd1, 2'd1, 2'd2);
        tick();
        respond({64'h0, e_ok}, 1'b0);
        check("v2_req_addr", bus.req_addr, 44'h000_0800_1230);
        tick();
        respond({pte1, pte0}, 1'b0);
        check("v2_write_wen", bus.write_wen, 1);
        check("v2_write_way", bus.write_way, 1);
        check("v2_write_data0", bus.write_data0, pte0);
        check("v2_write_data1", bus.write_data1, pte1);
        tick();

        // Reset while in L2_WAIT, then a stale response.
        issue_miss(mk_va(25'h0, 12'h011, 12'h022, 1'b0), 44'h0, 2'd1, 2'd1, 2'd1, 2'd0);
        tick();
        respond({64'h0, e_ok}, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_busy", bus.busy, 0);
        check("rr_miss_ready", bus.miss_ready, 1);
        check("rr_req_valid", bus.req_valid, 0);
        check("rr_write_way", bus.write_way, 0);
        check("rr_write_addr", bus.write_addr, 0);
        check("rr_write_data0", bus.write_data0, 0);
        respond({pte1, pte0}, 1'b0);
        check("rr_stale_wen", bus.write_wen, 0);
        check("rr_stale_fault", bus.fault, 0);
        check("rr_stale_busy", bus.busy, 0);
        tick();
        check("rr_stale_wen2", bus.write_wen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
